// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_pkg
//  Description : Field layout, constants, flag record and classification
//                helper for IEEE-754 binary16 values.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

    // Flag record in output order {nan, inf, zero, sign}
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sign;
    } fp16_flags_t;

    // Subnormals report as zero: only the exponent field is examined for zero
    function automatic fp16_flags_t fp16_classify(input logic [15:0] value);
        fp16_flags_t       flags;
        logic [EXP_W-1:0]  exp_f;
        logic [MAN_W-1:0]  man_f;
        exp_f      = value[MAN_W+EXP_W-1:MAN_W];
        man_f      = value[MAN_W-1:0];
        flags.zero = (exp_f == '0);
        flags.inf  = (exp_f == EXP_MAX) && (man_f == '0);
        flags.nan  = (exp_f == EXP_MAX) && (man_f != '0);
        flags.sign = value[15];
        return flags;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with full/empty
//                and occupancy count. A push while full is accepted when a
//                pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (count_q == c_CNT_W'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_pop_data = mem_q[rd_ptr_q];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Next-state for storage, pointers (power-of-two wrap) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - c_CNT_W'(1);
        end
    end

    // State registers; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu16_mul_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fpu16_mul_issue
//  Description : Operand issue / result collection around a registered fp16
//                multiplier. Buffers tagged operand pairs, issues one per
//                cycle when output credit allows, tracks in-flight products
//                in a valid/tag pipe and queues classified results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu16_mul_issue
    import fp16_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int MUL_LAT   = 1,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_a,
    input  logic [15:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    input  logic [15:0]       mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [3:0]        out_flags,
    output logic              busy
);

    localparam int c_IN_W   = 32 + TAG_W;
    localparam int c_OUT_W  = 16 + TAG_W + 4;
    localparam int c_ICNT_W = $clog2(IN_DEPTH) + 1;
    localparam int c_OCNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int c_INF_W  = $clog2(MUL_LAT + 2);
    localparam int c_SUM_W  = ((c_OCNT_W > c_INF_W) ? c_OCNT_W : c_INF_W) + 1;

    // Input FIFO
    logic                 w_in_push;
    logic [c_IN_W-1:0]    w_in_push_data;
    logic [c_IN_W-1:0]    w_in_pop_data;
    logic                 w_in_full;
    logic                 w_in_empty;
    logic [c_ICNT_W-1:0]  w_in_count;
    logic [15:0]          w_head_a;
    logic [15:0]          w_head_b;
    logic [TAG_W-1:0]     w_head_tag;

    // Output FIFO
    logic [c_OUT_W-1:0]   w_out_push_data;
    logic [c_OUT_W-1:0]   w_out_pop_data;
    logic                 w_out_full;
    logic                 w_out_empty;
    logic [c_OCNT_W-1:0]  w_out_count;
    fp16_flags_t          w_cap_flags;

    // Issue / pipe / credit
    logic                 w_issue;
    logic                 w_capture;
    logic [c_SUM_W-1:0]   w_credit_used;
    logic [15:0]          mul_a_q, mul_a_d;
    logic [15:0]          mul_b_q, mul_b_d;
    logic [MUL_LAT:0]     vld_q, vld_d;
    logic [TAG_W-1:0]     tag_q [MUL_LAT+1];
    logic [TAG_W-1:0]     tag_d [MUL_LAT+1];
    logic [c_INF_W-1:0]   inflight_q, inflight_d;

    // Ready depends only on registered occupancy (and reset), never on out_ready
    assign in_ready       = !w_in_full && !rst;
    assign w_in_push      = in_valid && in_ready;
    assign w_in_push_data = {in_a, in_b, in_tag};
    assign {w_head_a, w_head_b, w_head_tag} = w_in_pop_data;

    sync_fifo #(
        .WIDTH (c_IN_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_in_push),
        .i_push_data (w_in_push_data),
        .i_pop       (w_issue),
        .o_pop_data  (w_in_pop_data),
        .o_full      (w_in_full),
        .o_empty     (w_in_empty),
        .o_count     (w_in_count)
    );

    // Every slot already promised (queued or still in the multiplier) counts
    // against the output FIFO, so a capture always finds room
    assign w_credit_used = c_SUM_W'(w_out_count) + c_SUM_W'(inflight_q);
    assign w_issue       = !w_in_empty && (w_credit_used < c_SUM_W'(OUT_DEPTH));
    assign w_capture     = vld_q[MUL_LAT];

    // Operand registers, valid/tag pipe and in-flight counter next state
    always_comb begin
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        inflight_d = inflight_q;
        vld_d      = {vld_q[MUL_LAT-1:0], w_issue};
        tag_d[0]   = w_head_tag;
        for (int i = 1; i <= MUL_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (w_issue) begin
            mul_a_d = w_head_a;
            mul_b_d = w_head_b;
        end
        if (w_issue && !w_capture) begin
            inflight_d = inflight_q + c_INF_W'(1);
        end else if (!w_issue && w_capture) begin
            inflight_d = inflight_q - c_INF_W'(1);
        end
    end

    // Issue-side registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            vld_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

    assign w_cap_flags     = fp16_classify(mul_result);
    assign w_out_push_data = {mul_result, tag_q[MUL_LAT], w_cap_flags};

    sync_fifo #(
        .WIDTH (c_OUT_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_capture),
        .i_push_data (w_out_push_data),
        .i_pop       (out_ready),
        .o_pop_data  (w_out_pop_data),
        .o_full      (w_out_full),
        .o_empty     (w_out_empty),
        .o_count     (w_out_count)
    );

    assign out_valid = !w_out_empty;
    assign {out_result, out_tag, out_flags} = w_out_pop_data;
    assign busy = (w_in_count != '0) || (inflight_q != '0) || !w_out_empty;

    a_no_capture_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_capture && w_out_full));

endmodule
`default_nettype wire

// File: tb/tb_fpu16_mul_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu16_mul_issue
//  Description : Self-checking bench for fpu16_mul_issue with a behavioural
//                registered fp16 multiplier and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu16_mul_issue;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_a = '0;
    logic [15:0]       in_b = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [15:0]       mul_a;
    logic [15:0]       mul_b;
    logic [15:0]       mul_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_flags;
    logic              busy;
    logic              mul_rst_n;

    typedef struct packed {
        logic [15:0]      res;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;
    } exp_t;

    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
        logic [15:0]      res;
        logic [3:0]       flags;
    } vec_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   pop_cyc[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   pop_cnt  = 0;
    int   acc_cnt  = 0;

    always #5 clk = ~clk;

    fpu16_mul_issue #(
        .IN_DEPTH  (4),
        .OUT_DEPTH (4),
        .MUL_LAT   (1),
        .TAG_W     (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    // Reference fp16 multiply: truncating, flush-to-zero, quiet NaN 0x7E00
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [4:0]  ea, eb;
        logic [9:0]  fa, fb;
        logic [21:0] p;
        logic [9:0]  m;
        int          e;
        s  = a[15] ^ b[15];
        ea = a[14:10]; eb = b[14:10];
        fa = a[9:0];   fb = b[9:0];
        if ((ea == 5'd31 && fa != 0) || (eb == 5'd31 && fb != 0)) return 16'h7E00;
        if (ea == 5'd31 || eb == 5'd31) begin
            if (ea == 0 || eb == 0) return 16'h7E00;
            return {s, 5'd31, 10'd0};
        end
        if (ea == 0 || eb == 0) return {s, 15'd0};
        p = 22'({1'b1, fa}) * 22'({1'b1, fb});
        e = int'(ea) + int'(eb) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (e >= 31) return {s, 5'd31, 10'd0};
        if (e <= 0)  return {s, 15'd0};
        return {s, e[4:0], m};
    endfunction

    assign mul_rst_n = ~rst;

    always_ff @(posedge clk) begin
        if (!mul_rst_n) mul_result <= '0;
        else            mul_result <= fmul(mul_a, mul_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acceptance pushes the expectation; each output handshake pops and compares
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
            end else begin
                if (in_valid && in_ready) begin
                    sb.push_back(cur_exp);
                    acc_cnt++;
                end
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    pop_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got res=%h tag=%0d, expected none",
                                 out_result, out_tag);
                    end else begin
                        e = sb.pop_front();
                        check("result{res,tag,flags}", 32'({out_result, out_tag, out_flags}),
                              32'({e.res, e.tag, e.flags}));
                    end
                end
            end
        end
    endtask

    // Offer one pair and hold it until accepted; leaves in_valid asserted
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] tag,
                        input logic [15:0] res, input logic [3:0] fl);
        int n;
        n = 0;
        in_valid      = 1'b1;
        in_a          = a;
        in_b          = b;
        in_tag        = tag;
        cur_exp.res   = res;
        cur_exp.tag   = tag;
        cur_exp.flags = fl;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 300 && (sb.size() != 0 || busy)) begin
            @(negedge clk);
            n++;
        end
        check("drain{pending,busy}", {31'(sb.size()), busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t        tbl [8];
    int          p0, a0;
    logic [15:0] av;

    initial begin
        fork
            monitor();
        join_none

        // Table of operand pairs with expected product and flags {nan,inf,zero,sign}
        tbl[0] = '{a:16'h3E00, b:16'h3E00, tag:4'd0, res:16'h4080, flags:4'b0000};
        tbl[1] = '{a:16'hBE00, b:16'h3E00, tag:4'd1, res:16'hC080, flags:4'b0001};
        tbl[2] = '{a:16'hFC00, b:16'h3E00, tag:4'd2, res:16'hFC00, flags:4'b0101};
        tbl[3] = '{a:16'h0000, b:16'h4000, tag:4'd3, res:16'h0000, flags:4'b0010};
        tbl[4] = '{a:16'h3E00, b:16'hFE01, tag:4'd4, res:16'h7E00, flags:4'b1000};
        tbl[5] = '{a:16'h4000, b:16'h4000, tag:4'd5, res:16'h4400, flags:4'b0000};
        tbl[6] = '{a:16'h7BFF, b:16'h7BFF, tag:4'd6, res:16'h7C00, flags:4'b0100};
        tbl[7] = '{a:16'h3C00, b:16'hC000, tag:4'd7, res:16'hC000, flags:4'b0001};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_rst", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 32'd0);
        check("rst_out_fields", 32'({out_result, out_tag, out_flags}), 32'd0);
        @(posedge clk); #1;

        // Single pair latency: accepted at edge N, out_valid after edge N+3
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        in_a          = 16'h3E00;
        in_b          = 16'h3E00;
        in_tag        = 4'd5;
        cur_exp.res   = 16'h4080;
        cur_exp.tag   = 4'd5;
        cur_exp.flags = 4'b0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("latency_not_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        drain();

        // Back-to-back stream: one result per cycle, alternating sign
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(16'h3E00, 16'h3E00, 4'(i), 16'h4080, 4'b0000);
            else            send(16'hBE00, 16'h3E00, 4'(i), 16'hC080, 4'b0001);
        end
        in_valid = 1'b0;
        drain();
        check("stream_count", 32'(pop_cnt - p0), 32'd8);
        if (pop_cnt - p0 == 8)
            check("stream_one_per_cycle", 32'(pop_cyc[p0+7] - pop_cyc[p0]), 32'd7);

        // Table-driven specials and ordinary values
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].res, tbl[i].flags);
        end
        in_valid = 1'b0;
        drain();
        check("table_count", 32'(pop_cnt - p0), 32'd8);

        // Back-pressure: 8 acceptances, 4 issues, then release
        out_ready = 1'b0;
        p0 = pop_cnt;
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            av = 16'h3C00 + 16'(i) * 16'h0100;
            send(av, 16'h3C00, 4'(i), av, 4'b0000);
        end
        in_valid      = 1'b1;
        in_a          = 16'h4400;
        in_b          = 16'h3C00;
        in_tag        = 4'd8;
        cur_exp.res   = 16'h4400;
        cur_exp.tag   = 4'd8;
        cur_exp.flags = 4'b0000;
        repeat (5) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_accept_count", 32'(acc_cnt - a0), 32'd8);
        check("bp_mul_a_frozen", 32'(mul_a), 32'h3F00);
        check("bp_no_output", 32'(pop_cnt - p0), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h4400, 16'h3C00, 4'd8, 16'h4400, 4'b0000);
        send(16'h4500, 16'h3C00, 4'd9, 16'h4500, 4'b0000);
        in_valid = 1'b0;
        drain();
        check("bp_result_count", 32'(pop_cnt - p0), 32'd10);

        // Reset with work in flight and queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(16'h3E00, 16'h3E00, 4'(i), 16'h4080, 4'b0000);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        p0 = pop_cnt;
        out_ready = 1'b1;
        send(16'h4000, 16'h4000, 4'd9, 16'h4400, 4'b0000);
        in_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("midrst_single_result", 32'(pop_cnt - p0), 32'd1);
        @(posedge clk); #1;

        // Full FIFOs with continuous offer and toggling out_ready
        out_ready = 1'b0;
        p0 = pop_cnt;
        a0 = acc_cnt;
        fork
            begin
                repeat (6) @(posedge clk);
                repeat (40) begin
                    #1 out_ready = ~out_ready;
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    av = 16'h3C00 + 16'(i % 8) * 16'h0100;
                    send(av, 16'h3C00, 4'(i), av, 4'b0000);
                end
                in_valid = 1'b0;
            end
        join
        drain();
        check("toggle_accept_count", 32'(acc_cnt - a0), 32'd16);
        check("toggle_result_count", 32'(pop_cnt - p0), 32'd16);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
